// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, full/almost-full/empty flags and sticky overflow/underflow.
//
// Parameters:
//   DATASIZE     data word width in bits
//   ADDRSIZE     address bits, DEPTH = 2**ADDRSIZE entries
//   AFULL_THRESH almost-full occupancy threshold (1..DEPTH)
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   winc, wdata  write request and data
//   rinc         read request (pop in first-word-fall-through mode)
//   rdata        registered read data
//   wfull        FIFO full
//   walmost_full occupancy >= AFULL_THRESH
//   rempty       no word presentable
//   count        occupancy 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// Configuration:
//   SYNC_FIFO_FWFT_EN  when defined, rdata shows the head word whenever rempty=0;
//                      otherwise rdata loads on the edge a read is accepted.
module sync_fifo #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                walmost_full,
    output logic                rempty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int PW    = ADDRSIZE + 1;

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic                wfull_q, wfull_d, rempty_q, rempty_d, afull_q, afull_d;
    logic                overflow_q, overflow_d, underflow_q, underflow_d;
    logic                wr_en, rd_en;

    always_comb begin
        wr_en       = winc & ~wfull_q;
        rd_en       = rinc & ~rempty_q;
        wptr_d      = wptr_q + PW'(wr_en);
        rptr_d      = rptr_q + PW'(rd_en);
        count_d     = count_q + PW'(wr_en) - PW'(rd_en);
        wfull_d     = count_d == PW'(DEPTH);
        rempty_d    = count_d == '0;
        afull_d     = 32'(count_d) >= AFULL_THRESH;
        overflow_d  = overflow_q | (winc & wfull_q);
        underflow_d = underflow_q | (rinc & rempty_q);
`ifdef SYNC_FIFO_FWFT_EN
        // Preload the next head; when the word being written becomes the head
        // it is not in memory yet, so forward it straight from wdata.
        rdata_d = rempty_d ? rdata_q :
                  (wr_en && wptr_q == rptr_d) ? wdata : mem_q[rptr_d[ADDRSIZE-1:0]];
`else
        rdata_d = rd_en ? mem_q[rptr_q[ADDRSIZE-1:0]] : rdata_q;
`endif
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ADDRSIZE-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rdata        = rdata_q;
    assign wfull        = wfull_q;
    assign walmost_full = afull_q;
    assign rempty       = rempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL provide parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDRSIZE, default 4, address bits; DEPTH = 2^ADDRSIZE entries.
REQ-003 SHALL provide parameter AFULL_THRESH, default 12, almost-full occupancy threshold, legal range 1..DEPTH.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 winc  input  1  write request.
REQ-008 wdata  input  DATASIZE  write data, sampled with winc.
REQ-009 rinc  input  1  read request.
REQ-010 rdata  output  DATASIZE  read data, registered.
REQ-011 wfull  output  1  FIFO full, registered.
REQ-012 walmost_full  output  1  occupancy >= AFULL_THRESH, registered.
REQ-013 rempty  output  1  FIFO empty (no word presentable), registered.
REQ-014 count  output  ADDRSIZE+1  current occupancy 0..DEPTH, registered.
REQ-015 overflow  output  1  sticky: write attempted while full.
REQ-016 underflow  output  1  sticky: read attempted while empty.

Function
REQ-017 Write accepted iff winc=1 and wfull=0; wdata stored at write pointer, write pointer +1.
REQ-018 Read accepted iff rinc=1 and rempty=0; read pointer +1.
REQ-019 Pointers ADDRSIZE+1 bits binary, wrap modulo 2^(ADDRSIZE+1); MSB distinguishes full from empty.
REQ-020 count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or on neither.
REQ-021 wfull=1 iff next count = DEPTH; rempty=1 iff next count = 0; walmost_full=1 iff next count >= AFULL_THRESH; all updated same edge as count.
REQ-022 Full with winc=1 and rinc=1: read accepted, write rejected, count -> DEPTH-1, overflow set.
REQ-023 Empty with winc=1 and rinc=1: write accepted, read rejected, count -> 1, underflow set.
REQ-024 overflow sets on winc=1 with wfull=1; underflow sets on rinc=1 with rempty=1; both hold until reset.
REQ-025 Data order strictly FIFO; no word duplicated or lost across pointer wrap.
REQ-026 Storage array SHALL NOT be reset; contents beyond valid occupancy are don't-care.

Reset
REQ-027 rst_n=0 SHALL immediately force pointers=0, count=0, rempty=1, wfull=0, walmost_full=0, overflow=0, underflow=0, rdata=0.
REQ-028 Reset mid-operation discards all queued words; first accepted write after release is first word read.
REQ-029 Reset deassertion assumed synchronous to clk externally; no writes/reads accepted while rst_n=0.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-031 Without SYNC_FIFO_FWFT_EN: rdata loads word at read pointer on the edge a read is accepted (1-cycle latency); holds otherwise.
REQ-032 With SYNC_FIFO_FWFT_EN: rdata presents head word whenever rempty=0; rinc acknowledges/pops it; next head appears on rdata the edge after pop; rempty deasserts the edge after first write into empty FIFO.
REQ-033 Flag, count, overflow and underflow behaviour identical in both modes.

Verification (DATASIZE=8, ADDRSIZE=4, AFULL_THRESH=12)
REQ-034 Reset, write 0x01..0x10 (16 words) -> walmost_full rises after 12th write, wfull=1 and count=16 after 16th; 17th winc -> overflow=1, count stays 16.
REQ-035 From full, read 16 words -> rdata sequence 0x01..0x10 (latency 1 standard, 0 FWFT), rempty=1 after 16th; extra rinc -> underflow=1.
REQ-036 Stream 40 words with continuous winc and rinc at count=5 -> count holds 5, output order matches input across two pointer wraps.
REQ-037 Empty, winc=1 and rinc=1 same cycle with wdata=0xA5 -> count=1, underflow=1, next read returns 0xA5.
REQ-038 Write 8 words, assert rst_n=0 mid-cycle -> outputs reset immediately; after release write 0x3C, read -> 0x3C.
REQ-039 Run REQ-034..REQ-038 with and without SYNC_FIFO_FWFT_EN.
